// File: rtl/aes_inv_key_sched_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 inverse key schedule.
package aes_pkg;

   localparam int NR = 10;
   localparam int NK = 4;

   typedef logic [7:0]   rcon_t;
   typedef bit   [127:0] round_key_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      SERVE  = 2'd2
   } ks_state_e;

   localparam rcon_t RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (0 maps to 0), then the forward affine map.
   function automatic logic [7:0] sbox_byte(input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] r;
      p = b;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
             {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_inv_key_sched_sbox.sv
// Combinational forward SubWord: four byte S-boxes across a 32-bit word.
module aes_sbox_word
   import aes_pkg::*;
(
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   assign word_o[31:24] = sbox_byte(word_i[31:24]);
   assign word_o[23:16] = sbox_byte(word_i[23:16]);
   assign word_o[15:8]  = sbox_byte(word_i[15:8]);
   assign word_o[7:0]   = sbox_byte(word_i[7:0]);

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 key expansion that streams round keys 10..0 over valid/ready.
// Optional AES_KEY_REPLAY_EN adds a replay input that re-streams stored keys.
module aes_inv_key_sched
   import aes_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   input  logic [127:0] key_in,
   output logic         key_ready,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_idx,
`ifdef AES_KEY_REPLAY_EN
   input  logic         replay,
`endif
   output logic         busy
);

   if (DATA_WIDTH != 8) begin : g_bad_width
      $error("aes_inv_key_sched: DATA_WIDTH must be 8");
   end
   if (NUM_ROUNDS < 1 || NUM_ROUNDS > NR) begin : g_bad_rounds
      $error("aes_inv_key_sched: NUM_ROUNDS out of range");
   end

   localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

   ks_state_e    state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [3:0]   ptr_q, ptr_d;
   logic         loaded_q, loaded_d;
   logic         rk_valid_q, rk_valid_d;
   logic [127:0] rk_data_q, rk_data_d;
   logic [3:0]   rk_idx_q, rk_idx_d;

   round_key_t   kbuf_q [0:NUM_ROUNDS];
   logic         wr_en;
   logic [3:0]   wr_idx;
   logic [127:0] wr_data;

   logic [127:0] prev_key;
   logic [127:0] next_key;
   logic [31:0]  rot_w3;
   logic [31:0]  sub_w3;
   logic [31:0]  w0n, w1n, w2n, w3n;

   assign prev_key = kbuf_q[cnt_q - 4'd1];
   assign rot_w3   = {prev_key[23:0], prev_key[31:24]};

   aes_sbox_word u_sbox (
      .word_i (rot_w3),
      .word_o (sub_w3)
   );

   assign w0n      = prev_key[127:96] ^ sub_w3 ^ {RCON[cnt_q], 24'h0};
   assign w1n      = prev_key[95:64] ^ w0n;
   assign w2n      = prev_key[63:32] ^ w1n;
   assign w3n      = prev_key[31:0]  ^ w2n;
   assign next_key = {w0n, w1n, w2n, w3n};

   // In SERVE, rk_valid_q low means the first key is still to be loaded from the buffer.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      loaded_d   = loaded_q;
      rk_valid_d = rk_valid_q;
      rk_data_d  = rk_data_q;
      rk_idx_d   = rk_idx_q;
      wr_en      = 1'b0;
      wr_idx     = cnt_q;
      wr_data    = next_key;
      case (state_q)
         IDLE: begin
            if (key_valid) begin
               wr_en    = 1'b1;
               wr_idx   = 4'd0;
               wr_data  = key_in;
               cnt_d    = 4'd1;
               loaded_d = 1'b0;
               state_d  = EXPAND;
            end
`ifdef AES_KEY_REPLAY_EN
            else if (replay && loaded_q) begin
               ptr_d      = LAST;
               rk_valid_d = 1'b1;
               rk_data_d  = kbuf_q[LAST];
               rk_idx_d   = LAST;
               state_d    = SERVE;
            end
`endif
         end
         EXPAND: begin
            wr_en = 1'b1;
            if (cnt_q == LAST) begin
               ptr_d    = LAST;
               loaded_d = 1'b1;
               state_d  = SERVE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         SERVE: begin
            if (!rk_valid_q) begin
               rk_valid_d = 1'b1;
               rk_data_d  = kbuf_q[ptr_q];
               rk_idx_d   = ptr_q;
            end else if (rk_ready) begin
               if (ptr_q == 4'd0) begin
                  rk_valid_d = 1'b0;
                  state_d    = IDLE;
               end else begin
                  ptr_d     = ptr_q - 4'd1;
                  rk_data_d = kbuf_q[ptr_q - 4'd1];
                  rk_idx_d  = ptr_q - 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         ptr_q      <= 4'd0;
         loaded_q   <= 1'b0;
         rk_valid_q <= 1'b0;
         rk_data_q  <= 128'h0;
         rk_idx_q   <= 4'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         loaded_q   <= loaded_d;
         rk_valid_q <= rk_valid_d;
         rk_data_q  <= rk_data_d;
         rk_idx_q   <= rk_idx_d;
      end
   end

   // Key storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) kbuf_q[wr_idx] <= wr_data;
   end

   assign key_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign rk_valid  = rk_valid_q;
   assign rk_data   = rk_data_q;
   assign rk_idx    = rk_idx_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched; replay tests build when AES_KEY_REPLAY_EN is defined.
module tb_aes_inv_key_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_valid;
   logic [127:0] key_in;
   logic         key_ready;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_data;
   logic [3:0]   rk_idx;
   logic         busy;
`ifdef AES_KEY_REPLAY_EN
   logic         replay;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [127:0] rk;
      logic [3:0]   idx;
   } vec_t;

   vec_t vec [11];

   localparam logic [127:0] KEY_A     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_B     = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY_B_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] KEY_C     = 128'hdeadbeef0123456789abcdeffedcba98;

   aes_inv_key_sched dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_in    (key_in),
      .key_ready (key_ready),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk_data   (rk_data),
      .rk_idx    (rk_idx),
`ifdef AES_KEY_REPLAY_EN
      .replay    (replay),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Present a key for one accept edge; returns edges from accept to first rk_valid.
   task automatic send_key(input logic [127:0] k, input bit hold, output int lat);
      @(negedge clk);
      key_valid = 1'b1;
      key_in    = k;
      @(posedge clk);
      @(negedge clk);
      if (hold) key_in = KEY_C;
      else key_valid = 1'b0;
      lat = 0;
      while (!rk_valid && lat < 40) begin
         chk("key_ready_low_expand", 128'(key_ready), 128'd0);
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   // Consume the 11-key stream starting at a negedge with rk_valid high.
   task automatic run_stream(input bit stall);
      bit pat [4];
      int n;
      int cyc;
      bit rdy;
      logic [127:0] held_d;
      logic [3:0]   held_i;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      n   = 0;
      cyc = 0;
      while (n < 11 && cyc < 200) begin
         rdy      = stall ? pat[cyc % 4] : 1'b1;
         rk_ready = rdy;
         held_d   = rk_data;
         held_i   = rk_idx;
         chk("rk_valid_high", 128'(rk_valid), 128'd1);
         chk("key_ready_low_serve", 128'(key_ready), 128'd0);
         if (rdy) begin
            chk($sformatf("rk_idx_%0d", n), 128'(rk_idx), 128'(vec[n].idx));
            chk($sformatf("rk_data_%0d", n), rk_data, vec[n].rk);
            n++;
         end
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (!rdy) begin
            chk("stall_data_stable", rk_data, held_d);
            chk("stall_idx_stable", 128'(rk_idx), 128'(held_i));
         end
      end
      key_valid = 1'b0;
      chk("stream_transfer_count", 128'(n), 128'd11);
      chk("rk_valid_after_last", 128'(rk_valid), 128'd0);
      chk("key_ready_after_last", 128'(key_ready), 128'd1);
      chk("busy_after_last", 128'(busy), 128'd0);
   endtask

   initial begin
      int lat;
      int n;
      rst       = 1'b1;
      key_valid = 1'b0;
      key_in    = 128'h0;
      rk_ready  = 1'b0;
`ifdef AES_KEY_REPLAY_EN
      replay    = 1'b0;
`endif
      vec[0]  = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10};
      vec[1]  = '{128'hac7766f319fadc2128d12941575c006e, 4'd9};
      vec[2]  = '{128'head27321b58dbad2312bf5607f8d292f, 4'd8};
      vec[3]  = '{128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 4'd7};
      vec[4]  = '{128'h6d88a37a110b3efddbf98641ca0093fd, 4'd6};
      vec[5]  = '{128'hd4d1c6f87c839d87caf2b8bc11f915bc, 4'd5};
      vec[6]  = '{128'hef44a541a8525b7fb671253bdb0bad00, 4'd4};
      vec[7]  = '{128'h3d80477d4716fe3e1e237e446d7a883b, 4'd3};
      vec[8]  = '{128'hf2c295f27a96b9435935807a7359f67f, 4'd2};
      vec[9]  = '{128'ha0fafe1788542cb123a339392a6c7605, 4'd1};
      vec[10] = '{KEY_A, 4'd0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_key_ready", 128'(key_ready), 128'd1);
      chk("reset_rk_valid", 128'(rk_valid), 128'd0);
      chk("reset_rk_data", rk_data, 128'd0);
      chk("reset_rk_idx", 128'(rk_idx), 128'd0);
      chk("reset_busy", 128'(busy), 128'd0);

      // Full stream with consumer always ready.
      send_key(KEY_A, 1'b0, lat);
      chk("latency_a", 128'(lat), 128'd11);
      chk("busy_serve", 128'(busy), 128'd1);
      run_stream(1'b0);

`ifdef AES_KEY_REPLAY_EN
      replay = 1'b1;
      @(posedge clk);
      @(negedge clk);
      replay = 1'b0;
      chk("replay_valid", 128'(rk_valid), 128'd1);
      chk("replay_idx", 128'(rk_idx), 128'd10);
      run_stream(1'b0);
`endif

      // Backpressure pattern 1,0,0,1.
      send_key(KEY_A, 1'b0, lat);
      chk("latency_stall", 128'(lat), 128'd11);
      run_stream(1'b1);

      // key_valid held with a different key while busy.
      send_key(KEY_A, 1'b1, lat);
      chk("latency_hold", 128'(lat), 128'd11);
      run_stream(1'b0);

      // Reset in the middle of expansion, then restart with another key.
      @(negedge clk);
      key_valid = 1'b1;
      key_in    = KEY_A;
      @(posedge clk);
      @(negedge clk);
      key_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_expand_busy", 128'(busy), 128'd0);
      chk("rst_expand_key_ready", 128'(key_ready), 128'd1);
      chk("rst_expand_rk_valid", 128'(rk_valid), 128'd0);
      send_key(KEY_B, 1'b0, lat);
      chk("latency_b", 128'(lat), 128'd11);
      chk("key_b_idx10", 128'(rk_idx), 128'd10);
      chk("key_b_rk10", rk_data, KEY_B_R10);
      rk_ready = 1'b1;
      n = 0;
      while (rk_idx != 4'd0 && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      chk("key_b_steps", 128'(n), 128'd10);
      chk("key_b_rk0", rk_data, KEY_B);
      chk("key_b_rk0_valid", 128'(rk_valid), 128'd1);
      @(posedge clk);
      @(negedge clk);
      chk("key_b_done_valid", 128'(rk_valid), 128'd0);

      // Reset while serving round 6.
      send_key(KEY_A, 1'b0, lat);
      rk_ready = 1'b1;
      n = 0;
      while (rk_idx != 4'd6 && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      chk("serve_reach_idx6", 128'(rk_idx), 128'd6);
      chk("serve_idx6_data", rk_data, vec[4].rk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_serve_rk_valid", 128'(rk_valid), 128'd0);
      chk("rst_serve_key_ready", 128'(key_ready), 128'd1);
      chk("rst_serve_busy", 128'(busy), 128'd0);

`ifdef AES_KEY_REPLAY_EN
      replay = 1'b1;
      @(posedge clk);
      @(negedge clk);
      replay = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("replay_after_rst_valid", 128'(rk_valid), 128'd0);
         chk("replay_after_rst_busy", 128'(busy), 128'd0);
         @(posedge clk);
         @(negedge clk);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
